// File: rtl/hpu_vram_arbiter.sv
// hpu_vram_arbiter
// Shares the single VRAM port between the tile fetcher and the CPU access
// port, one access per clock. During active display tile fetches win, but a
// starvation counter hands the CPU one slot after CPU_STARVE_MAX consecutive
// denied cycles. Read data is routed back to the requester that issued the
// read, using an owner tag pipeline matched to the VRAM read latency.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   active_display      raster inside visible area (tile priority)
//   tile_req/addr       tile fetch read request; tile_gnt accepts it (comb)
//   tile_rvalid/rdata   tile read return
//   cpu_req/we/addr/wdata  CPU access request; cpu_gnt accepts it (comb)
//   cpu_rvalid/rdata    CPU read return
//   mem_addr/en/we/wdata   registered VRAM command
//   mem_rdata           VRAM read data, valid RD_LAT cycles after the command
//   cpu_starved         starvation counter is saturated (registered)
module hpu_vram_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int CPU_STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_display,
  input  logic              tile_req,
  input  logic [ADDR_W-1:0] tile_addr,
  output logic              tile_gnt,
  output logic              tile_rvalid,
  output logic [DATA_W-1:0] tile_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_starved
);

  localparam int              CNT_W      = 8;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(CPU_STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              cpu_starved_q, cpu_starved_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  // Bit k set: the read issued k+1 cycles ago belongs to that requester.
  logic [RD_LAT:0]   own_tile_q, own_tile_d;
  logic [RD_LAT:0]   own_cpu_q, own_cpu_d;
  logic              cpu_win;

  // Arbitration: CPU wins when alone, outside display, or when starved.
  always_comb begin
    cpu_win = 1'b0;
    if (cpu_req) begin
      if (!tile_req || !active_display || (starve_cnt_q == STARVE_MAX)) begin
        cpu_win = 1'b1;
      end else begin
        cpu_win = 1'b0;
      end
    end else begin
      cpu_win = 1'b0;
    end
    cpu_gnt  = cpu_win;
    tile_gnt = tile_req & ~cpu_win;
  end

  // Starvation counter: counts consecutive denied CPU cycles, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || cpu_gnt) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (starve_cnt_q == STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    // Registered flag tracks the counter value it will be compared against.
    cpu_starved_d = (starve_cnt_d == STARVE_MAX);
  end

  // Issue: capture the winner's command; address/data hold when idle.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if (tile_gnt) begin
      mem_addr_d = tile_addr;
      mem_en_d   = 1'b1;
      mem_we_d   = 1'b0;
    end else if (cpu_gnt) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      mem_en_d    = 1'b1;
      mem_we_d    = cpu_we;
    end else begin
      mem_en_d = 1'b0;
      mem_we_d = 1'b0;
    end
  end

  // Owner tag shift: writes and idle slots carry no tag.
  always_comb begin
    own_tile_d = {own_tile_q[RD_LAT-1:0], tile_gnt};
    own_cpu_d  = {own_cpu_q[RD_LAT-1:0], cpu_gnt & ~cpu_we};
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q  <= {CNT_W{1'b0}};
      cpu_starved_q <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= {DATA_W{1'b0}};
      own_tile_q    <= {(RD_LAT+1){1'b0}};
      own_cpu_q     <= {(RD_LAT+1){1'b0}};
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      cpu_starved_q <= cpu_starved_d;
      mem_addr_q    <= mem_addr_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      own_tile_q    <= own_tile_d;
      own_cpu_q     <= own_cpu_d;
    end
  end

  // Read return: VRAM data passes straight through to the tagged owner.
  always_comb begin
    tile_rvalid = own_tile_q[RD_LAT];
    cpu_rvalid  = own_cpu_q[RD_LAT];
    tile_rdata  = tile_rvalid ? mem_rdata : {DATA_W{1'b0}};
    cpu_rdata   = cpu_rvalid ? mem_rdata : {DATA_W{1'b0}};
  end

  assign mem_addr    = mem_addr_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_starved = cpu_starved_q;

endmodule

// File: tb/tb_hpu_vram_arbiter.sv
// Bench for hpu_vram_arbiter: two instances (RD_LAT = 1 and RD_LAT = 3) share
// one stimulus stream and one VRAM model; reads are scoreboarded per port.
module tb_hpu_vram_arbiter;

  localparam int MAXS = 8;

  typedef struct {
    logic        ad;
    logic        treq;
    logic [15:0] taddr;
    logic        creq;
    logic        cwe;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        etg;
    logic        ecg;
    logic        est;
  } vec_t;

  typedef struct packed {
    int         due;
    logic [7:0] d;
  } ret_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        active_display, tile_req, cpu_req, cpu_we;
  logic [15:0] tile_addr, cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        tile_gnt1, tile_rvalid1, cpu_gnt1, cpu_rvalid1, mem_en1, mem_we1, cpu_starved1;
  logic [7:0]  tile_rdata1, cpu_rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;
  logic        tile_gnt3, tile_rvalid3, cpu_gnt3, cpu_rvalid3, mem_en3, mem_we3, cpu_starved3;
  logic [7:0]  tile_rdata3, cpu_rdata3, mem_wdata3, mem_rdata3;
  logic [15:0] mem_addr3;

  hpu_vram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1), .CPU_STARVE_MAX(MAXS)) u_dut1 (
    .clk(clk), .reset(reset), .active_display(active_display),
    .tile_req(tile_req), .tile_addr(tile_addr), .tile_gnt(tile_gnt1),
    .tile_rvalid(tile_rvalid1), .tile_rdata(tile_rdata1),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .mem_addr(mem_addr1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .cpu_starved(cpu_starved1));

  hpu_vram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(3), .CPU_STARVE_MAX(MAXS)) u_dut3 (
    .clk(clk), .reset(reset), .active_display(active_display),
    .tile_req(tile_req), .tile_addr(tile_addr), .tile_gnt(tile_gnt3),
    .tile_rvalid(tile_rvalid3), .tile_rdata(tile_rdata3),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
    .mem_addr(mem_addr3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .cpu_starved(cpu_starved3));

  // VRAM model: shared array, latency-1 and latency-3 read pipes.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  logic [7:0] vmem [0:65535];
  logic       init_done = 1'b0;
  logic [7:0] rd1_q = 8'h00;
  logic [7:0] rd3_q [0:2];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) vmem[i] <= pat(16'(i));
      init_done <= 1'b1;
    end else if (mem_en1 && mem_we1) begin
      vmem[mem_addr1] <= mem_wdata1;
    end
    rd1_q    <= vmem[mem_addr1];
    rd3_q[0] <= vmem[mem_addr3];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign mem_rdata1 = rd1_q;
  assign mem_rdata3 = rd3_q[2];

  // Scoreboard state
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  ret_t        tq1[$], cq1[$], tq3[$], cq3[$];
  logic [7:0]  ovr [logic [15:0]];
  logic        pend_en = 1'b0, pend_we = 1'b0;
  logic [15:0] hold_addr = 16'h0000;
  logic [7:0]  hold_wd = 8'h00;

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (ovr.exists(a)) return ovr[a];
    return pat(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
  endtask

  task automatic chk_ret(input string nm, input logic rv, input logic [7:0] rd,
                         input int qsize, input ret_t fr, output logic pop);
    if (qsize > 0 && fr.due == cyc) begin
      chk({nm, "_rvalid"}, {63'd0, rv}, 64'd1);
      chk({nm, "_rdata"}, {56'd0, rd}, {56'd0, fr.d});
      pop = 1'b1;
    end else begin
      chk({nm, "_rvalid"}, {63'd0, rv}, 64'd0);
      chk({nm, "_rdata"}, {56'd0, rd}, 64'd0);
      pop = 1'b0;
    end
  endtask

  task automatic check_returns();
    ret_t fr;
    logic pop;
    fr = '0; if (tq1.size() > 0) fr = tq1[0];
    chk_ret("tile_l1", tile_rvalid1, tile_rdata1, tq1.size(), fr, pop);
    if (pop) void'(tq1.pop_front());
    fr = '0; if (cq1.size() > 0) fr = cq1[0];
    chk_ret("cpu_l1", cpu_rvalid1, cpu_rdata1, cq1.size(), fr, pop);
    if (pop) void'(cq1.pop_front());
    fr = '0; if (tq3.size() > 0) fr = tq3[0];
    chk_ret("tile_l3", tile_rvalid3, tile_rdata3, tq3.size(), fr, pop);
    if (pop) void'(tq3.pop_front());
    fr = '0; if (cq3.size() > 0) fr = cq3[0];
    chk_ret("cpu_l3", cpu_rvalid3, cpu_rdata3, cq3.size(), fr, pop);
    if (pop) void'(cq3.pop_front());
  endtask

  function automatic vec_t mk(input logic ad, input logic treq, input logic [15:0] taddr,
                              input logic creq, input logic cwe, input logic [15:0] caddr,
                              input logic [7:0] cwd, input logic etg, input logic ecg,
                              input logic est);
    vec_t v;
    v.ad = ad; v.treq = treq; v.taddr = taddr; v.creq = creq; v.cwe = cwe;
    v.caddr = caddr; v.cwd = cwd; v.etg = etg; v.ecg = ecg; v.est = est;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
  endfunction

  // One clock: drive after the edge, check at the falling edge, then queue
  // the consequences of the expected grant.
  task automatic cyc_step(input vec_t v);
    @(posedge clk);
    #1;
    active_display = v.ad; tile_req = v.treq; tile_addr = v.taddr;
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    cyc++;
    @(negedge clk);
    chk("tile_gnt_l1", {63'd0, tile_gnt1}, {63'd0, v.etg});
    chk("cpu_gnt_l1", {63'd0, cpu_gnt1}, {63'd0, v.ecg});
    chk("gnt_l3", {62'd0, tile_gnt3, cpu_gnt3}, {62'd0, v.etg, v.ecg});
    chk("cpu_starved", {62'd0, cpu_starved1, cpu_starved3}, {62'd0, v.est, v.est});
    chk("mem_en_we", {62'd0, mem_en1, mem_we1}, {62'd0, pend_en, pend_we});
    chk("mem_addr", {48'd0, mem_addr1}, {48'd0, hold_addr});
    chk("mem_wdata", {56'd0, mem_wdata1}, {56'd0, hold_wd});
    check_returns();
    pend_en = 1'b0;
    pend_we = 1'b0;
    if (v.etg) begin
      pend_en = 1'b1;
      hold_addr = v.taddr;
      tq1.push_back('{due: cyc + 2, d: exp_rd(v.taddr)});
      tq3.push_back('{due: cyc + 4, d: exp_rd(v.taddr)});
    end else if (v.ecg) begin
      pend_en = 1'b1;
      pend_we = v.cwe;
      hold_addr = v.caddr;
      hold_wd = v.cwd;
      if (v.cwe) ovr[v.caddr] = v.cwd;
      else begin
        cq1.push_back('{due: cyc + 2, d: exp_rd(v.caddr)});
        cq3.push_back('{due: cyc + 4, d: exp_rd(v.caddr)});
      end
    end
  endtask

  // One clock with reset held low: every output must read zero.
  task automatic rst_step();
    @(posedge clk);
    #1;
    reset = 1'b0;
    active_display = 1'b0; tile_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cyc++;
    @(negedge clk);
    chk("rst_outs_l1", {17'd0, tile_gnt1, tile_rvalid1, tile_rdata1, cpu_gnt1, cpu_rvalid1,
                        cpu_rdata1, mem_addr1, mem_en1, mem_we1, mem_wdata1, cpu_starved1}, 64'd0);
    chk("rst_outs_l3", {17'd0, tile_gnt3, tile_rvalid3, tile_rdata3, cpu_gnt3, cpu_rvalid3,
                        cpu_rdata3, mem_addr3, mem_en3, mem_we3, mem_wdata3, cpu_starved3}, 64'd0);
    tq1.delete(); cq1.delete(); tq3.delete(); cq3.delete();
    pend_en = 1'b0; pend_we = 1'b0; hold_addr = 16'h0000; hold_wd = 8'h00;
  endtask

  vec_t tbl[$];

  initial begin
    int g;
    reset = 1'b0;
    active_display = 1'b0; tile_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    tile_addr = 16'h0000; cpu_addr = 16'h0000; cpu_wdata = 8'h00;

    // Table: tile burst, write-then-read, display-off CPU priority,
    // display-on takeover, alternating CPU/tile reads.
    tbl.push_back(mk(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 16'h0102, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) tbl.push_back(idle());
    tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2000, 8'hA5, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) tbl.push_back(idle());
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0, 1'b1, 16'h0800, 1'b1, 1'b0, 16'(16'h0700 + k), 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 16'h0800, 1'b1, 1'b0, 16'h0705, 8'h00, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) tbl.push_back(idle());
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'(16'h0050 + k), 8'h00, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 16'(16'h0060 + k), 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0));
    end
    for (int k = 0; k < 6; k++) tbl.push_back(idle());

    // Reset state, then a tile read cut off by reset must never return.
    rst_step();
    rst_step();
    reset = 1'b1;
    cyc_step(mk(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0));
    rst_step();
    rst_step();
    rst_step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) cyc_step(idle());

    foreach (tbl[i]) cyc_step(tbl[i]);

    // Continuous contention in display: CPU wins every ninth cycle.
    g = 0;
    for (int i = 1; i <= 27; i++) begin
      logic s;
      s = ((i % (MAXS + 1)) == 0);
      cyc_step(mk(1'b1, 1'b1, 16'(16'h0400 + i), 1'b1, 1'b0, 16'(16'h3000 + g), 8'h00,
                  ~s, s, s));
      if (s) g++;
    end
    for (int k = 0; k < 6; k++) cyc_step(idle());

    // Dropping cpu_req restarts the starvation count.
    for (int i = 1; i <= 5; i++)
      cyc_step(mk(1'b1, 1'b1, 16'(16'h0500 + i), 1'b1, 1'b0, 16'h3100, 8'h00, 1'b1, 1'b0, 1'b0));
    cyc_step(mk(1'b1, 1'b1, 16'h0510, 1'b0, 1'b0, 16'h3100, 8'h00, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i <= 9; i++) begin
      logic s;
      s = (i == 9);
      cyc_step(mk(1'b1, 1'b1, 16'(16'h0520 + i), 1'b1, 1'b0, 16'h3100, 8'h00, ~s, s, s));
    end
    for (int k = 0; k < 6; k++) cyc_step(idle());

    chk("drain", {32'd0, 32'(tq1.size() + cq1.size() + tq3.size() + cq3.size())}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
